// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states and the request record.
package rv32i_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IMEM,
        ARB_DMEM
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic req_valid(input mem_req_t r);
        return |{r.rmask, r.wmask};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and downstream memory ports of the arbiter.
interface mem_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    // Arbiter side
    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    // Core plus memory model side
    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_arbiter_slot.sv
// One-deep pending request slot for a single requester; ignores new requests while full or in flight.
module arb_req_slot
    import rv32i_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  mem_req_t i_req,
    input  logic     i_block,
    input  logic     i_grant,
    output logic     o_pending,
    output mem_req_t o_req,
    output logic     o_accept
);

    logic     r_pending;
    mem_req_t r_req;

    assign o_accept  = req_valid(i_req) && !r_pending && !i_block;
    assign o_pending = r_pending;
    assign o_req     = r_req;

    // A grant on the accepting cycle issues the request directly, so it is never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_req     <= '0;
        end else if (i_grant) begin
            r_pending <= 1'b0;
        end else if (o_accept) begin
            r_pending <= 1'b1;
            r_req     <= i_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes fetch and data requests onto one memory port and routes each response to its owner.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter bit DMEM_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    mem_req_t   r_mem;

    mem_req_t   w_imem_in;
    mem_req_t   w_dmem_in;
    mem_req_t   w_imem_slot;
    mem_req_t   w_dmem_slot;
    mem_req_t   w_imem_sel;
    mem_req_t   w_dmem_sel;
    logic       w_imem_pending;
    logic       w_dmem_pending;
    logic       w_imem_accept;
    logic       w_dmem_accept;
    logic       w_imem_avail;
    logic       w_dmem_avail;
    logic       w_imem_block;
    logic       w_dmem_block;
    logic       w_grant_i;
    logic       w_grant_d;

    assign w_imem_in = '{addr: bus.imem_addr, rmask: bus.imem_rmask, wmask: 4'h0, wdata: 32'h0};
    assign w_dmem_in = '{addr: bus.dmem_addr, rmask: bus.dmem_rmask,
                         wmask: bus.dmem_wmask, wdata: bus.dmem_wdata};

    // The owner may re-request in its response cycle; otherwise an in-flight port is deaf.
    assign w_imem_block = (r_state == ARB_IMEM) && !bus.mem_resp;
    assign w_dmem_block = (r_state == ARB_DMEM) && !bus.mem_resp;

    arb_req_slot u_imem_slot (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_imem_in),
        .i_block   (w_imem_block),
        .i_grant   (w_grant_i),
        .o_pending (w_imem_pending),
        .o_req     (w_imem_slot),
        .o_accept  (w_imem_accept)
    );

    arb_req_slot u_dmem_slot (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_dmem_in),
        .i_block   (w_dmem_block),
        .i_grant   (w_grant_d),
        .o_pending (w_dmem_pending),
        .o_req     (w_dmem_slot),
        .o_accept  (w_dmem_accept)
    );

    // A request arriving while IDLE competes immediately so its pulse lands in the next cycle.
    assign w_imem_avail = w_imem_pending || w_imem_accept;
    assign w_dmem_avail = w_dmem_pending || w_dmem_accept;
    assign w_imem_sel   = w_imem_pending ? w_imem_slot : w_imem_in;
    assign w_dmem_sel   = w_dmem_pending ? w_dmem_slot : w_dmem_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_imem_avail && (!w_dmem_avail || !DMEM_FIRST)) begin
                    w_grant_i    = 1'b1;
                    w_next_state = ARB_IMEM;
                end else if (w_dmem_avail) begin
                    w_grant_d    = 1'b1;
                    w_next_state = ARB_DMEM;
                end
            end
            ARB_IMEM, ARB_DMEM: begin
                if (bus.mem_resp) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Masks pulse for one cycle; address and data stay put until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '0;
        end else if (w_grant_i) begin
            r_mem <= w_imem_sel;
        end else if (w_grant_d) begin
            r_mem <= w_dmem_sel;
        end else begin
            r_mem.rmask <= 4'h0;
            r_mem.wmask <= 4'h0;
        end
    end

    assign bus.mem_addr   = r_mem.addr;
    assign bus.mem_rmask  = r_mem.rmask;
    assign bus.mem_wmask  = r_mem.wmask;
    assign bus.mem_wdata  = r_mem.wdata;

    assign bus.imem_resp  = !rst && (r_state == ARB_IMEM) && bus.mem_resp;
    assign bus.dmem_resp  = !rst && (r_state == ARB_DMEM) && bus.mem_resp;
    assign bus.imem_rdata = bus.mem_rdata;
    assign bus.dmem_rdata = bus.mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory/cache port between the pipeline's instruction-fetch requester (IF/ID) and data requester (MEM). Each request is captured into a per-requester pending slot, serialized onto the downstream port one at a time, and the response is routed back to the owner. Sits between the pipeline core and the unified cache/memory model.

## Interface
- DMEM_FIRST, 1, when 1 the data requester wins simultaneous grants; when 0 the instruction requester wins
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- imem_addr  in  32  fetch address, 4-byte aligned
- imem_rmask  in  4  fetch read mask; nonzero for one cycle = request
- imem_rdata  out  32  fetch data, valid with imem_resp
- imem_resp  out  1  one-cycle fetch completion
- dmem_addr  in  32  data address
- dmem_rmask  in  4  data read mask
- dmem_wmask  in  4  data write mask; rmask and wmask are never both nonzero
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data, valid with dmem_resp
- dmem_resp  out  1  one-cycle data completion
- mem_addr  out  32  downstream address
- mem_rmask  out  4  downstream read mask, one-cycle pulse
- mem_wmask  out  4  downstream write mask, one-cycle pulse
- mem_wdata  out  32  downstream store data
- mem_rdata  in  32  downstream read data
- mem_resp  in  1  downstream one-cycle completion

## Operation
- Request = cycle with nonzero mask on that port; the request is latched into the port's pending slot (addr, masks, wdata) at the clock edge.
- Each requester has at most one request outstanding; a new request from a port whose slot is occupied or in flight is a protocol violation and is ignored.
- FSM states: IDLE, IMEM, DMEM.
- IDLE: if any slot is pending, select the winner (DMEM_FIRST priority), drive its request onto mem_* for exactly one cycle, clear its slot, go to IMEM/DMEM.
- IMEM/DMEM: mem_* masks 0, mem_addr/mem_wdata held. On mem_resp: pulse the owner's resp for that same cycle, imem_rdata/dmem_rdata = mem_rdata, return to IDLE.
- The non-owner's resp stays 0; mem_resp in IDLE is dropped.
- imem_rdata and dmem_rdata both continuously mirror mem_rdata; only the corresponding resp qualifies them.
- Reset at any point: state IDLE, both slots cleared, in-flight request abandoned; a late mem_resp is dropped.
- Reset values: mem_addr 0, mem_rmask 0, mem_wmask 0, mem_wdata 0, imem_resp 0, dmem_resp 0.

## Timing
- Request latched at edge E; downstream pulse is driven in cycle E+1 (registered mem_* outputs) when the FSM is IDLE.
- Downstream resp in cycle R -> requester resp in cycle R (combinational routing from mem_resp and state).
- Back-to-back: with the other slot pending at R, its downstream pulse is driven in cycle R+2 (IDLE at R+1, issue at R+2).
- Minimum requester round trip = 2 cycles plus downstream latency.
- A request arriving in cycle R, with the slot freed earlier, is accepted normally.
- Simultaneous requests in IDLE: the winner issues at E+1 and the loser stays pending; the loser issues in the cycle after the winner's resp + 1.

## Structure
- Shared package (rv32i_types): enum arb_state_t {ARB_IDLE, ARB_IMEM, ARB_DMEM}; struct mem_req_t {addr[31:0], rmask[3:0], wmask[3:0], wdata[31:0]}.
- Sub-module arb_req_slot, instantiated twice:
  - latches a mem_req_t on nonzero mask when empty
  - clears on grant
  - exposes a pending flag and the stored request
- The top holds the FSM, the grant mux and the response demux.

## Test plan
- Single fetch:
  - imem_rmask=4'hF, addr 0x6000_0000 at cycle 1 -> mem_rmask=F, mem_addr=0x6000_0000 at cycle 2.
  - mem_resp with rdata 0x0000_0013 at cycle 5 -> imem_resp=1, imem_rdata=0x13 at cycle 5, dmem_resp=0.
- Simultaneous, DMEM_FIRST=1:
  - stimulus: imem read 0x6000_0004 and dmem write 0x7000_0000, wmask 4'h3, wdata 0xBEEF, in the same cycle.
  - -> dmem write issues first; imem read issues 2 cycles after the dmem resp.
  - -> each resp reaches only its owner.
- Stall interplay: dmem request arrives while the IMEM state is in flight -> the request waits in its slot and issues at resp+2, addr and wdata unchanged.
- Spurious resp: mem_resp=1 while IDLE -> no imem_resp or dmem_resp pulse; state stays IDLE.
- Reset mid-operation:
  - stimulus: rst asserted during the DMEM state with imem pending, followed by a mem_resp.
  - -> all outputs at reset values, both slots empty, the late mem_resp is dropped.
- DMEM_FIRST=0, simultaneous requests -> the imem request issues first.
